// File: rtl/jtframe_dump_trigger.sv
// Capture-window controller: counts frames on VS falling edges after ROM download and
// opens dump_en at a programmed start frame for a programmed number of frames.
module jtframe_dump_trigger #(
  parameter int FW = 32,
  parameter int LW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vs,
  input  logic          downloading,
  input  logic          arm,
  input  logic          abort,
  input  logic [FW-1:0] start_frame,
  input  logic [LW-1:0] length,
  output logic [FW-1:0] frame_cnt,
  output logic          dump_en,
  output logic          done,
  output logic          busy
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DL,
    WAIT_START,
    CAPTURE,
    DONE
  } state_t;

  state_t        r_state;
  logic          r_vs_l;
  logic          w_fe;
  logic [FW-1:0] r_start;
  logic [LW-1:0] r_length;
  logic [LW-1:0] r_len;

  function automatic logic [FW-1:0] sat_inc(input logic [FW-1:0] v);
    return (&v) ? v : v + FW'(1);
  endfunction

  assign w_fe = r_vs_l & ~vs;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vs_l    <= 1'b0;
      frame_cnt <= '0;
    end else begin
      r_vs_l    <= vs;
      if (downloading)
        frame_cnt <= '0;
      else if (w_fe)
        frame_cnt <= sat_inc(frame_cnt);
    end
  end

  // abort outranks everything; downloading only interrupts the frame-driven states
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      dump_en <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
      r_len   <= '0;
    end else if (abort) begin
      r_state <= IDLE;
      dump_en <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (arm) begin
            r_state  <= WAIT_DL;
            busy     <= 1'b1;
            r_start  <= start_frame;
            r_length <= length;
          end
        end
        WAIT_DL: begin
          if (!downloading)
            r_state <= WAIT_START;
        end
        WAIT_START: begin
          if (downloading) begin
            r_state <= WAIT_DL;
          end else if (w_fe && frame_cnt == r_start) begin
            r_state <= CAPTURE;
            dump_en <= 1'b1;
            r_len   <= r_length;
          end
        end
        CAPTURE: begin
          if (downloading) begin
            r_state <= WAIT_DL;
            dump_en <= 1'b0;
          end else if (w_fe) begin
            if (r_len == LW'(1)) begin
              r_state <= DONE;
              dump_en <= 1'b0;
              done    <= 1'b1;
              busy    <= 1'b0;
            end else if (r_len != '0) begin
              r_len <= r_len - LW'(1);
            end
          end
        end
        DONE: begin
          if (arm) begin
            r_state  <= WAIT_DL;
            done     <= 1'b0;
            busy     <= 1'b1;
            r_start  <= start_frame;
            r_length <= length;
          end
        end
        default: begin
          r_state <= IDLE;
          dump_en <= 1'b0;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtframe_dump_trigger.sv
// Directed bench for jtframe_dump_trigger: frame counting, capture windows, download
// interruption, abort/arm priority, late start and counter saturation.
module tb_jtframe_dump_trigger;

  logic        clk = 1'b0;
  logic        rst, vs, downloading, arm, abort;
  logic [31:0] start_frame;
  logic [15:0] length;
  logic [31:0] frame_cnt;
  logic        dump_en, done, busy;
  logic [3:0]  s_frame_cnt;
  logic        s_dump_en, s_done, s_busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  jtframe_dump_trigger #(.FW(32), .LW(16)) dut (
    .clk(clk), .rst(rst), .vs(vs), .downloading(downloading),
    .arm(arm), .abort(abort), .start_frame(start_frame), .length(length),
    .frame_cnt(frame_cnt), .dump_en(dump_en), .done(done), .busy(busy)
  );

  // narrow counter instance used to observe saturation in a reasonable number of frames
  jtframe_dump_trigger #(.FW(4), .LW(4)) dut_sat (
    .clk(clk), .rst(rst), .vs(vs), .downloading(downloading),
    .arm(1'b0), .abort(1'b0), .start_frame(4'd0), .length(4'd0),
    .frame_cnt(s_frame_cnt), .dump_en(s_dump_en), .done(s_done), .busy(s_busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame();
    vs = 1'b1;
    cyc(2);
    vs = 1'b0;
    cyc(2);
  endtask

  task automatic pulse_arm(input logic [31:0] s, input logic [15:0] l);
    start_frame = s;
    length      = l;
    arm         = 1'b1;
    cyc(1);
    arm         = 1'b0;
  endtask

  initial begin
    rst = 1'b1; vs = 1'b0; downloading = 1'b0; arm = 1'b0; abort = 1'b0;
    start_frame = '0; length = '0;
    cyc(2);
    rst = 1'b0;
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_dump_en", dump_en, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);

    // free-running frame count
    repeat (5) frame();
    check("cnt5_frame_cnt", frame_cnt, 5);
    check("cnt5_dump_en", dump_en, 0);
    check("cnt5_busy", busy, 0);

    // basic capture: start 3, length 2
    rst = 1'b1; cyc(1); rst = 1'b0;
    pulse_arm(32'd3, 16'd2);
    check("arm_busy", busy, 1);
    cyc(1);
    repeat (3) frame();
    check("b_pre_dump_en", dump_en, 0);
    check("b_pre_cnt", frame_cnt, 3);
    frame();
    check("b_open_dump_en", dump_en, 1);
    check("b_open_cnt", frame_cnt, 4);
    frame();
    check("b_mid_dump_en", dump_en, 1);
    check("b_mid_done", done, 0);
    frame();
    check("b_end_dump_en", dump_en, 0);
    check("b_end_done", done, 1);
    check("b_end_busy", busy, 0);
    check("b_end_cnt", frame_cnt, 6);
    cyc(5);
    check("b_done_held", done, 1);

    // download during WAIT_START restarts the frame count
    pulse_arm(32'd3, 16'd2);
    check("re_arm_done_clr", done, 0);
    cyc(1);
    frame();
    check("ws_cnt7", frame_cnt, 7);
    downloading = 1'b1;
    cyc(1);
    check("dl_cnt_zero", frame_cnt, 0);
    cyc(99);
    check("dl_busy", busy, 1);
    check("dl_cnt_held", frame_cnt, 0);
    downloading = 1'b0;
    cyc(1);
    repeat (3) frame();
    check("dl_pre_dump_en", dump_en, 0);
    frame();
    check("dl_open_dump_en", dump_en, 1);
    check("dl_open_cnt", frame_cnt, 4);

    // download during CAPTURE drops the window but keeps the configuration
    downloading = 1'b1;
    cyc(1);
    check("cdl_dump_en", dump_en, 0);
    check("cdl_busy", busy, 1);
    check("cdl_cnt", frame_cnt, 0);
    downloading = 1'b0;
    cyc(1);
    repeat (3) frame();
    check("cdl_pre_dump_en", dump_en, 0);
    frame();
    check("cdl_open_dump_en", dump_en, 1);
    repeat (2) frame();
    check("cdl_done", done, 1);
    check("cdl_end_dump_en", dump_en, 0);
    check("cdl_end_cnt", frame_cnt, 6);

    // unlimited length from frame 0, then abort
    downloading = 1'b1;
    pulse_arm(32'd0, 16'd0);
    cyc(1);
    downloading = 1'b0;
    cyc(1);
    frame();
    check("u_open_dump_en", dump_en, 1);
    check("u_open_cnt", frame_cnt, 1);
    repeat (11) frame();
    check("u_long_dump_en", dump_en, 1);
    check("u_long_done", done, 0);
    check("u_long_cnt", frame_cnt, 12);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    check("abort_dump_en", dump_en, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);

    // arm and abort together from IDLE: abort wins
    arm = 1'b1; abort = 1'b1;
    cyc(1);
    arm = 1'b0; abort = 1'b0;
    check("armabort_busy", busy, 0);
    cyc(1);
    check("armabort_busy2", busy, 0);

    // arm during CAPTURE is ignored
    downloading = 1'b1;
    pulse_arm(32'd1, 16'd3);
    cyc(1);
    downloading = 1'b0;
    cyc(1);
    frame();
    check("ig_pre_dump_en", dump_en, 0);
    frame();
    check("ig_open_dump_en", dump_en, 1);
    pulse_arm(32'd0, 16'd10);
    check("ig_busy", busy, 1);
    repeat (2) frame();
    check("ig_mid_dump_en", dump_en, 1);
    frame();
    check("ig_end_dump_en", dump_en, 0);
    check("ig_end_done", done, 1);
    check("ig_end_cnt", frame_cnt, 5);

    // start frame already passed: never triggers
    repeat (2) frame();
    check("late_cnt7", frame_cnt, 7);
    pulse_arm(32'd2, 16'd1);
    cyc(1);
    repeat (20) frame();
    check("late_dump_en", dump_en, 0);
    check("late_busy", busy, 1);
    check("late_done", done, 0);
    check("late_cnt", frame_cnt, 27);
    check("sat_cnt", s_frame_cnt, 4'hF);

    // synchronous reset while armed
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("rst2_busy", busy, 0);
    check("rst2_dump_en", dump_en, 0);
    check("rst2_done", done, 0);
    check("rst2_cnt", frame_cnt, 0);
    check("rst2_sat_cnt", s_frame_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
